// File: rtl/riscv_hwloop_pkg.sv
// Shared definitions for the hardware-loop controller: default loop count
// and the controller FSM state encoding.
package riscv_hwloop_pkg;

  localparam int N_HWLP_DEFAULT = 2;

  // IDLE: evaluating loop-end matches; REQ: jump to loop start pending in IF.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } hwlp_state_e;

endpackage

// File: rtl/riscv_hwloop_match.sv
// Per-loop end-address comparators with lowest-index priority select.
// Produces a one-hot match vector, the winning loop's start address and
// whether the winning loop still has more than one iteration left.
module riscv_hwloop_match
  import riscv_hwloop_pkg::*;
#(
  parameter int N_HWLP = N_HWLP_DEFAULT
) (
  input  logic                 instr_valid_i,
  input  logic [31:0]          current_pc_i,
  input  logic [N_HWLP*32-1:0] hwlp_start_addr_i,
  input  logic [N_HWLP*32-1:0] hwlp_end_addr_i,
  input  logic [N_HWLP*32-1:0] hwlp_counter_i,
  output logic [N_HWLP-1:0]    match_onehot_o,
  output logic [31:0]          sel_start_o,
  output logic                 sel_more_iter_o
);

  // Compare every loop, then keep only the lowest-index hit so the innermost
  // loop owns a shared end address.
  always_comb begin
    logic found;
    logic [31:0] cnt;
    found           = 1'b0;
    cnt             = 32'h0;
    match_onehot_o  = '0;
    sel_start_o     = 32'h0;
    sel_more_iter_o = 1'b0;
    for (int i = 0; i < N_HWLP; i++) begin
      cnt = hwlp_counter_i[i*32 +: 32];
      if (!found && instr_valid_i &&
          (current_pc_i == hwlp_end_addr_i[i*32 +: 32]) &&
          (cnt != 32'h0)) begin
        found             = 1'b1;
        match_onehot_o[i] = 1'b1;
        sel_start_o       = hwlp_start_addr_i[i*32 +: 32];
        sel_more_iter_o   = (cnt > 32'd1);
      end
    end
  end

endmodule

// File: rtl/riscv_hwloop_ctrl.sv
// Hardware-loop controller: on a loop-end hit in ID it strobes the counter
// decrement in the same cycle and, unless this was the last iteration,
// requests a jump back to the loop start while stalling ID until IF accepts.
// Handshake: hwlp_jump_o acts as valid and fetch_ready_i as ready; the
// request (and hwlp_target_o) is held stable until a cycle where both are
// high, or until flush_i kills it.
module riscv_hwloop_ctrl
  import riscv_hwloop_pkg::*;
#(
  parameter int N_HWLP = N_HWLP_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          current_pc_i,
  input  logic                 instr_valid_i,
  input  logic [N_HWLP*32-1:0] hwlp_start_addr_i,
  input  logic [N_HWLP*32-1:0] hwlp_end_addr_i,
  input  logic [N_HWLP*32-1:0] hwlp_counter_i,
  input  logic                 fetch_ready_i,
  input  logic                 flush_i,
  output logic [N_HWLP-1:0]    hwlp_dec_cnt_o,
  output logic                 hwlp_jump_o,
  output logic [31:0]          hwlp_target_o,
  output logic                 stall_o
);

  hwlp_state_e        state_q, state_d;
  logic [31:0]        target_q, target_d;
  logic [N_HWLP-1:0]  match_onehot;
  logic [31:0]        sel_start;
  logic               sel_more_iter;

  riscv_hwloop_match #(.N_HWLP(N_HWLP)) u_match (
    .instr_valid_i     (instr_valid_i),
    .current_pc_i      (current_pc_i),
    .hwlp_start_addr_i (hwlp_start_addr_i),
    .hwlp_end_addr_i   (hwlp_end_addr_i),
    .hwlp_counter_i    (hwlp_counter_i),
    .match_onehot_o    (match_onehot),
    .sel_start_o       (sel_start),
    .sel_more_iter_o   (sel_more_iter)
  );

  // Next-state, target capture and zero-latency decrement strobe.
  always_comb begin
    state_d        = state_q;
    target_d       = target_q;
    hwlp_dec_cnt_o = '0;
    case (state_q)
      IDLE: begin
        // A flush kills the instruction in ID, so its loop hit is ignored.
        if (!flush_i && (match_onehot != '0)) begin
          hwlp_dec_cnt_o = match_onehot;
          if (sel_more_iter) begin
            state_d  = REQ;
            target_d = sel_start;
          end
        end
      end
      REQ: begin
        if (flush_i || fetch_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and target registers; reset drops any pending jump at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      target_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  assign hwlp_jump_o   = (state_q == REQ);
  assign stall_o       = (state_q == REQ);
  assign hwlp_target_o = target_q;

endmodule

// File: doc/riscv_hwloop_ctrl.md
RISCV_HWLOOP_CTRL -- requirements
Module: riscv_hwloop_ctrl

Interface
REQ-001 SHALL have parameter: N_HWLP, default 2, number of hardware loop register sets; index 0 is the innermost loop.
REQ-002 SHALL have port: clk  input  1  core clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: current_pc_i  input  32  PC of the instruction in ID.
REQ-005 SHALL have port: instr_valid_i  input  1  the ID instruction is valid and retiring this cycle.
REQ-006 SHALL have port: hwlp_start_addr_i  input  N_HWLP*32  loop start addresses from the hwloop register file.
REQ-007 SHALL have port: hwlp_end_addr_i  input  N_HWLP*32  loop end addresses (address of the last loop-body instruction).
REQ-008 SHALL have port: hwlp_counter_i  input  N_HWLP*32  remaining iteration counts.
REQ-009 SHALL have port: fetch_ready_i  input  1  IF stage accepts a jump request this cycle.
REQ-010 SHALL have port: flush_i  input  1  branch/exception kill of pending control flow.
REQ-011 SHALL have port: hwlp_dec_cnt_o  output  N_HWLP  one-hot decrement strobe to the register file.
REQ-012 SHALL have port: hwlp_jump_o  output  1  jump request to IF.
REQ-013 SHALL have port: hwlp_target_o  output  32  jump target, valid while hwlp_jump_o is high.
REQ-014 SHALL have port: stall_o  output  1  holds ID while a jump request is pending.

Function
REQ-015 Loop i SHALL match when instr_valid_i=1, current_pc_i == end[i], and counter[i] != 0 (32-bit unsigned compare).
REQ-016 With several matches, the lowest index SHALL win; other loops SHALL NOT be decremented in that cycle.
REQ-017 FSM states SHALL be IDLE and REQ; matching is evaluated only in IDLE.
REQ-018 In IDLE, on a winning match i, hwlp_dec_cnt_o[i] SHALL pulse high combinationally in that same cycle (zero latency), for exactly one cycle.
REQ-019 If counter[i] > 1 at the match, start[i] SHALL be captured into a target register and the FSM SHALL go to REQ at the next edge.
REQ-020 If counter[i] == 1, the controller SHALL decrement only and remain in IDLE (fall-through; last iteration).
REQ-021 In REQ, hwlp_jump_o and stall_o SHALL be 1 and hwlp_target_o SHALL hold the captured start address; no decrement SHALL be issued.
REQ-022 In REQ with fetch_ready_i=1, the FSM SHALL return to IDLE at the next edge; hwlp_jump_o SHALL be high for at least one cycle, one cycle after the match.
REQ-023 flush_i=1 SHALL force IDLE at the next edge and suppress any match decrement in that cycle; flush_i wins over simultaneous fetch_ready_i.
REQ-024 Counter values 0 SHALL be treated as inactive; 32'hFFFFFFFF SHALL be treated as a normal count (no sign handling).
REQ-025 hwlp_dec_cnt_o SHALL never have more than one bit set.

Reset
REQ-026 On rst_n low, the FSM SHALL be IDLE and the target register 32'h0, asynchronously.
REQ-027 During and after reset, hwlp_jump_o=0, stall_o=0, hwlp_target_o=0, and hwlp_dec_cnt_o=0 until a match.
REQ-028 Reset asserted while in REQ SHALL drop the pending jump immediately with no further decrement.

Structure
REQ-029 A shared package riscv_hwloop_pkg SHALL hold the N_HWLP default and the FSM state typedef (IDLE, REQ).
REQ-030 The per-loop comparator and lowest-index priority select SHALL be one sub-module, riscv_hwloop_match, producing the one-hot match and the selected start address.

Verification
REQ-031 Scenario: loop0 start=0x100, end=0x10C, cnt=3; PC=0x10C valid -> dec[0] pulse the same cycle; next cycle jump=1, target=0x100; fetch_ready -> IDLE.
REQ-032 Scenario: cnt=1, PC=end -> dec[0] pulse, jump stays 0, FSM stays IDLE.
REQ-033 Scenario: loop0 and loop1 both end=0x200, cnt0=2, cnt1=5 -> dec=2'b01 only, target=start0.
REQ-034 Scenario: REQ held with fetch_ready=0 for 3 cycles -> jump/stall high all 3 cycles, target stable, no dec pulses.
REQ-035 Scenario: flush_i and fetch_ready_i both high in REQ -> IDLE next cycle; flush in an IDLE match cycle -> dec=0.
REQ-036 Scenario: rst_n low mid-REQ -> jump=0, target=0 immediately; cnt=0 with PC=end -> no dec, no jump.
